// File: rtl/rf_bypass_sb_if.sv
// rtl/rf_bypass_sb_if.sv - decode read, writeback write and issue ports of rf_bypass_sb
interface rf_bypass_sb_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3
);
    logic [SEL_W-1:0]  read1RegSel;
    logic [SEL_W-1:0]  read2RegSel;
    logic [DATA_W-1:0] read1Data;
    logic [DATA_W-1:0] read2Data;
    logic              read1Busy;
    logic              read2Busy;
    logic [SEL_W-1:0]  writeRegSel;
    logic [DATA_W-1:0] writeData;
    logic              writeEn;
    logic              issueEn;
    logic [SEL_W-1:0]  issueRegSel;
    logic              err;

    modport master (
        output read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
               issueEn, issueRegSel,
        input  read1Data, read2Data, read1Busy, read2Busy, err
    );

    modport slave (
        input  read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
               issueEn, issueRegSel,
        output read1Data, read2Data, read1Busy, read2Busy, err
    );
endinterface

// File: rtl/rf_bypass_sb.sv
// rtl/rf_bypass_sb.sv - register file with pending-write scoreboard; RF_BYPASS_EN adds same-cycle write-to-read bypass
module rf_bypass_sb #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    rf_bypass_sb_if.slave     bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  cnt  [NREG];
    logic              err_q;
    logic              err_set;
    logic [NREG-1:0]   issue_hit;
    logic [NREG-1:0]   wr_hit;

    // Issue and writeback to the same register cancel, so only the unpaired
    // side of each register can over- or underflow its counter.
    always_comb begin
        err_set   = 1'b0;
        issue_hit = '0;
        wr_hit    = '0;
        for (int r = 0; r < NREG; r++) begin
            issue_hit[r] = bus.issueEn && (bus.issueRegSel == SEL_W'(r));
            wr_hit[r]    = bus.writeEn && (bus.writeRegSel == SEL_W'(r));
            if (issue_hit[r] && !wr_hit[r] && (cnt[r] == CNT_MAX))
                err_set = 1'b1;
            if (wr_hit[r] && !issue_hit[r] && (cnt[r] == '0))
                err_set = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (bus.writeEn)
                regs[bus.writeRegSel] <= bus.writeData;
            for (int r = 0; r < NREG; r++) begin
                if (issue_hit[r] && !wr_hit[r] && (cnt[r] != CNT_MAX))
                    cnt[r] <= cnt[r] + CNT_ONE;
                else if (wr_hit[r] && !issue_hit[r] && (cnt[r] != '0))
                    cnt[r] <= cnt[r] - CNT_ONE;
            end
            if (err_set)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        bus.read1Data = regs[bus.read1RegSel];
        bus.read2Data = regs[bus.read2RegSel];
        bus.read1Busy = (cnt[bus.read1RegSel] != '0);
        bus.read2Busy = (cnt[bus.read2RegSel] != '0);
`ifdef RF_BYPASS_EN
        // The last outstanding producer retiring this cycle frees the register now.
        if (wr_hit[bus.read1RegSel]) begin
            bus.read1Data = bus.writeData;
            if ((cnt[bus.read1RegSel] == CNT_ONE) && !issue_hit[bus.read1RegSel])
                bus.read1Busy = 1'b0;
        end
        if (wr_hit[bus.read2RegSel]) begin
            bus.read2Data = bus.writeData;
            if ((cnt[bus.read2RegSel] == CNT_ONE) && !issue_hit[bus.read2RegSel])
                bus.read2Busy = 1'b0;
        end
`endif
        bus.err = err_q;
    end
endmodule

// File: tb/tb_rf_bypass_sb.sv
// tb/tb_rf_bypass_sb.sv - scoreboard bench for rf_bypass_sb, with or without RF_BYPASS_EN
module tb_rf_bypass_sb;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_bypass_sb_if #(.DATA_W(16), .SEL_W(3)) bus ();

    rf_bypass_sb #(.DATA_W(16), .NREG(8), .SEL_W(3), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] d1;
        logic [15:0] d2;
        logic        b1;
        logic        b2;
        logic        e;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [15:0] m_reg [8];
    logic [1:0]  m_cnt [8];
    logic        m_err;

    task automatic chk(input string tag, input string name, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s.%s got %h expected %h", tag, name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.tag, "read1Data", bus.read1Data, e.d1);
            chk(e.tag, "read2Data", bus.read2Data, e.d2);
            chk(e.tag, "read1Busy", 16'(bus.read1Busy), 16'(e.b1));
            chk(e.tag, "read2Busy", 16'(bus.read2Busy), 16'(e.b2));
            chk(e.tag, "err", 16'(bus.err), 16'(e.e));
        end
    end

    task automatic drive(input logic [2:0] s1, input logic [2:0] s2, input logic we,
                         input logic [2:0] ws, input logic [15:0] wd, input logic ie,
                         input logic [2:0] is);
        bus.read1RegSel = s1;
        bus.read2RegSel = s2;
        bus.writeEn     = we;
        bus.writeRegSel = ws;
        bus.writeData   = wd;
        bus.issueEn     = ie;
        bus.issueRegSel = is;
    endtask

    task automatic push(input logic [15:0] d1, input logic [15:0] d2, input logic b1,
                        input logic b2, input logic e, input string tag);
        exp_t x;
        x.d1 = d1; x.d2 = d2; x.b1 = b1; x.b2 = b2; x.e = e; x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic dstep(input logic [2:0] s1, input logic [2:0] s2, input logic we,
                         input logic [2:0] ws, input logic [15:0] wd, input logic ie,
                         input logic [2:0] is, input logic [15:0] e1, input logic [15:0] e2,
                         input logic eb1, input logic eb2, input logic ee, input string tag);
        drive(s1, s2, we, ws, wd, ie, is);
        push(e1, e2, eb1, eb2, ee, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int r = 0; r < 8; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = '0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic [15:0] m_rd(input logic [2:0] s, input logic we, input logic [2:0] ws,
                                         input logic [15:0] wd);
        m_rd = m_reg[s];
        if (BYP && we && ws == s) m_rd = wd;
    endfunction

    function automatic logic m_busy(input logic [2:0] s, input logic we, input logic [2:0] ws,
                                    input logic ie, input logic [2:0] is);
        m_busy = (m_cnt[s] != 2'd0);
        if (BYP && m_cnt[s] == 2'd1 && we && ws == s && !(ie && is == s)) m_busy = 1'b0;
    endfunction

    task automatic rstep(input logic do_rst, input logic [2:0] s1, input logic [2:0] s2,
                         input logic we, input logic [2:0] ws, input logic [15:0] wd,
                         input logic ie, input logic [2:0] is);
        rst = do_rst;
        if (do_rst) m_reset();
        drive(s1, s2, we, ws, wd, ie, is);
        push(m_rd(s1, we, ws, wd), m_rd(s2, we, ws, wd), m_busy(s1, we, ws, ie, is),
             m_busy(s2, we, ws, ie, is), m_err, "rand");
        if (!do_rst) begin
            for (int r = 0; r < 8; r++) begin
                logic ih, wh;
                ih = ie && is == 3'(r);
                wh = we && ws == 3'(r);
                if (ih && !wh) begin
                    if (m_cnt[r] == 2'd3) m_err = 1'b1;
                    else m_cnt[r] = m_cnt[r] + 2'd1;
                end else if (wh && !ih) begin
                    if (m_cnt[r] == 2'd0) m_err = 1'b1;
                    else m_cnt[r] = m_cnt[r] - 2'd1;
                end
            end
            if (we) m_reg[ws] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(3'd0, 3'd3, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        dstep(0, 3, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, "reset");
        rst = 1'b0;

        // 0xBEEF to r5 with a matching issue first
        dstep(5, 0, 0, 0, 16'h0, 1, 5, 16'h0, 16'h0, 0, 0, 0, "r5_issue");
        dstep(5, 5, 1, 5, 16'hBEEF, 0, 0, BYP ? 16'hBEEF : 16'h0, BYP ? 16'hBEEF : 16'h0,
              !BYP, !BYP, 0, "r5_write");
        dstep(5, 5, 0, 0, 16'h0, 0, 0, 16'hBEEF, 16'hBEEF, 0, 0, 0, "r5_after");

        // two producers on r2, retired one at a time
        dstep(2, 0, 0, 0, 16'h0, 1, 2, 16'h0, 16'h0, 0, 0, 0, "r2_iss1");
        dstep(2, 0, 0, 0, 16'h0, 1, 2, 16'h0, 16'h0, 1, 0, 0, "r2_iss2");
        dstep(2, 0, 1, 2, 16'h0022, 0, 0, BYP ? 16'h0022 : 16'h0, 16'h0, 1, 0, 0, "r2_wr1");
        dstep(2, 2, 1, 2, 16'h0033, 0, 0, BYP ? 16'h0033 : 16'h0022, BYP ? 16'h0033 : 16'h0022,
              !BYP, !BYP, 0, "r2_wr2");
        dstep(2, 5, 0, 0, 16'h0, 0, 0, 16'h0033, 16'hBEEF, 0, 0, 0, "r2_done");

        // issue and write r7 together at cnt=0
        dstep(7, 0, 1, 7, 16'h7777, 1, 7, BYP ? 16'h7777 : 16'h0, 16'h0, 0, 0, 0, "r7_both");
        dstep(7, 7, 0, 0, 16'h0, 0, 0, 16'h7777, 16'h7777, 0, 0, 0, "r7_after");

        // r3 pending with data, then asynchronous reset mid-cycle
        dstep(3, 0, 0, 0, 16'h0, 1, 3, 16'h0, 16'h0, 0, 0, 0, "r3_iss");
        dstep(3, 0, 1, 3, 16'h1234, 1, 3, BYP ? 16'h1234 : 16'h0, 16'h0, 1, 0, 0, "r3_wr_iss");
        dstep(3, 0, 0, 0, 16'h0, 0, 0, 16'h1234, 16'h0, 1, 0, 0, "r3_held");
        rst = 1'b1;
        dstep(3, 0, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, "rst_mid");
        rst = 1'b0;
        dstep(3, 5, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, "post_rst");

        // unexpected writeback, then issue saturation and drain
        dstep(4, 0, 1, 4, 16'h4444, 0, 0, BYP ? 16'h4444 : 16'h0, 16'h0, 0, 0, 0, "r4_unexp");
        dstep(4, 1, 0, 0, 16'h0, 1, 1, 16'h4444, 16'h0, 0, 0, 1, "r1_iss1");
        dstep(4, 1, 0, 0, 16'h0, 1, 1, 16'h4444, 16'h0, 0, 1, 1, "r1_iss2");
        dstep(4, 1, 0, 0, 16'h0, 1, 1, 16'h4444, 16'h0, 0, 1, 1, "r1_iss3");
        dstep(4, 1, 0, 0, 16'h0, 1, 1, 16'h4444, 16'h0, 0, 1, 1, "r1_iss4");
        dstep(4, 1, 0, 0, 16'h0, 0, 0, 16'h4444, 16'h0, 0, 1, 1, "r1_sat");
        dstep(4, 1, 1, 1, 16'h0001, 0, 0, 16'h4444, BYP ? 16'h0001 : 16'h0, 0, 1, 1, "r1_wr1");
        dstep(4, 1, 1, 1, 16'h0002, 0, 0, 16'h4444, BYP ? 16'h0002 : 16'h0001, 0, 1, 1, "r1_wr2");
        dstep(4, 1, 1, 1, 16'h0003, 0, 0, 16'h4444, BYP ? 16'h0003 : 16'h0002, 0, !BYP, 1, "r1_wr3");
        dstep(4, 1, 0, 0, 16'h0, 0, 0, 16'h4444, 16'h0003, 0, 0, 1, "r1_empty");
        rst = 1'b1;
        dstep(4, 1, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, "err_clr");

        // random traffic against the reference model, periodic resets
        rstep(1'b1, 0, 0, 0, 0, 16'h0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            rstep((i % 80) == 79, 3'($urandom_range(7)), 3'($urandom_range(7)),
                  1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom),
                  1'($urandom_range(1)), 3'($urandom_range(7)));
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 16'h0, 0, 0);

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
